// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the cache memory-bus master.
package mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_DATA,
        WR_REQ,
        DONE
    } state_t;

    localparam int WORD_W = 32;
    localparam logic [3:0] BE_FULL = 4'b1111;
    localparam int LINE_WORDS_DEF = 4;

endpackage

// File: rtl/cache_bus_master_if.sv
// cache_bus_master_if: cache request/fill side plus Avalon-MM master side.
interface cache_bus_master_if #(
    parameter int LINE_WORDS = mem_pkg::LINE_WORDS_DEF
);
    localparam int IDX_W = $clog2(LINE_WORDS);

    logic                     req_valid;
    logic                     req_ready;
    logic                     req_write;
    logic [mem_pkg::WORD_W-1:0] req_addr;
    logic [mem_pkg::WORD_W-1:0] req_wdata;
    logic [3:0]               req_byteenable;
    logic                     fill_valid;
    logic [IDX_W-1:0]         fill_idx;
    logic [mem_pkg::WORD_W-1:0] fill_data;
    logic                     resp_valid;
    logic                     busy;
    logic [mem_pkg::WORD_W-1:0] address;
    logic                     read;
    logic                     write;
    logic                     waitrequest;
    logic [mem_pkg::WORD_W-1:0] writedata;
    logic [3:0]               byteenable;
    logic [mem_pkg::WORD_W-1:0] readdata;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_byteenable,
        input  waitrequest, readdata,
        output req_ready, fill_valid, fill_idx, fill_data, resp_valid, busy,
        output address, read, write, writedata, byteenable
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_byteenable,
        output waitrequest, readdata,
        input  req_ready, fill_valid, fill_idx, fill_data, resp_valid, busy,
        input  address, read, write, writedata, byteenable
    );

endinterface

// File: rtl/cache_bus_master.sv
// cache_bus_master: turns cache line refills and write-through stores into
// single-outstanding Avalon-MM word transfers.
module cache_bus_master
    import mem_pkg::*;
#(
    parameter int LINE_WORDS = LINE_WORDS_DEF
) (
    input logic clk,
    input logic reset,
    cache_bus_master_if.master bus
);
    localparam int IDX_W = $clog2(LINE_WORDS);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic [29:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic              last, rd, wr;

    assign last = cnt_q == IDX_W'(LINE_WORDS - 1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        case (state_q)
            IDLE: if (bus.req_valid) begin
                state_d = bus.req_write ? WR_REQ : RD_REQ;
                cnt_d   = '0;
                addr_d  = bus.req_addr[31:2];
                wdata_d = bus.req_wdata;
                be_d    = bus.req_byteenable;
            end
            RD_REQ:  state_d = bus.waitrequest ? RD_REQ : RD_DATA;
            RD_DATA: begin
                state_d = last ? DONE : RD_REQ;
                cnt_d   = last ? cnt_q : cnt_q + 1'b1;
            end
            WR_REQ:  state_d = bus.waitrequest ? WR_REQ : DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
        end
    end

    // Every output decodes straight from flops, so read/write/address stay
    // stable for as long as waitrequest holds the state.
    assign rd = state_q == RD_REQ;
    assign wr = state_q == WR_REQ;

    assign bus.req_ready  = state_q == IDLE;
    assign bus.busy       = state_q != IDLE;
    assign bus.read       = rd;
    assign bus.write      = wr;
    assign bus.fill_valid = state_q == RD_DATA;
    assign bus.fill_idx   = cnt_q;
    assign bus.fill_data  = bus.readdata;
    assign bus.resp_valid = state_q == DONE;
    assign bus.address    = rd ? {addr_q[29:IDX_W], cnt_q, 2'b00} : wr ? {addr_q, 2'b00} : '0;
    assign bus.byteenable = rd ? BE_FULL : wr ? be_q : 4'b0000;
    assign bus.writedata  = wr ? wdata_q : '0;

endmodule

// File: tb/tb_cache_bus_master.sv
// tb_cache_bus_master: directed per-cycle vector tables plus hand-written
// reset and back-to-back request sequences.
module tb_cache_bus_master;
    import mem_pkg::*;

    localparam logic [31:0] WA = 32'hA1A2_A3A4;
    localparam logic [31:0] WB = 32'hB1B2_B3B4;
    localparam logic [31:0] WC = 32'hC1C2_C3C4;
    localparam logic [31:0] WD = 32'hD1D2_D3D4;

    typedef struct {
        logic        wt;
        logic        rd, wr, fv, rsp, rdy;
        logic [31:0] adr, wd, fd;
        logic [3:0]  be;
        logic [1:0]  idx;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    vec_t tbl[$];

    cache_bus_master_if #(.LINE_WORDS(4)) bus();

    cache_bus_master #(.LINE_WORDS(4)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_rd(logic [31:0] a);
        case (a)
            32'h1230: return WA;
            32'h1234: return WB;
            32'h1238: return WC;
            32'h123C: return WD;
            default:  return 32'hBAD0_BAD0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) bus.readdata <= '0;
        else if (bus.read && !bus.waitrequest) bus.readdata <= mem_rd(bus.address);
    end

    function automatic vec_t mk(logic wt, logic rd, logic wr, logic fv, logic rsp, logic rdy,
                                logic [31:0] adr, logic [31:0] wd, logic [31:0] fd,
                                logic [3:0] be, logic [1:0] idx);
        vec_t v;
        v.wt = wt; v.rd = rd; v.wr = wr; v.fv = fv; v.rsp = rsp; v.rdy = rdy;
        v.adr = adr; v.wd = wd; v.fd = fd; v.be = be; v.idx = idx;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_rows(int lo, int hi);
        for (int i = lo; i <= hi; i++) begin
            vec_t v = tbl[i];
            bus.waitrequest = v.wt;
            #1;
            chk($sformatf("row%0d read", i), bus.read, v.rd);
            chk($sformatf("row%0d write", i), bus.write, v.wr);
            chk($sformatf("row%0d fill_valid", i), bus.fill_valid, v.fv);
            chk($sformatf("row%0d resp_valid", i), bus.resp_valid, v.rsp);
            chk($sformatf("row%0d req_ready", i), bus.req_ready, v.rdy);
            chk($sformatf("row%0d busy", i), bus.busy, !v.rdy);
            if (v.rd || v.wr) begin
                chk($sformatf("row%0d address", i), bus.address, v.adr);
                chk($sformatf("row%0d byteenable", i), bus.byteenable, v.be);
            end
            if (v.wr) chk($sformatf("row%0d writedata", i), bus.writedata, v.wd);
            if (v.fv) begin
                chk($sformatf("row%0d fill_idx", i), bus.fill_idx, v.idx);
                chk($sformatf("row%0d fill_data", i), bus.fill_data, v.fd);
            end
            @(negedge clk);
        end
    endtask

    task automatic start_req(logic w, logic [31:0] a, logic [31:0] d, logic [3:0] be);
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr = a;
        bus.req_wdata = d;
        bus.req_byteenable = be;
        #1;
        chk("accept req_ready", bus.req_ready, 1);
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Refill of 0x1234 with no stalls: rows 0..9 are cycles 1..10.
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 32'h1230, 0, 0, 4'hF, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, WA, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 32'h1234, 0, 0, 4'hF, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, WB, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 32'h1238, 0, 0, 4'hF, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, WC, 0, 2));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 32'h123C, 0, 0, 4'hF, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, WD, 0, 3));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        // Same refill, three stall cycles on word 2: rows 10..22 are cycles 1..13.
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 32'h1230, 0, 0, 4'hF, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, WA, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 32'h1234, 0, 0, 4'hF, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, WB, 0, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 32'h1238, 0, 0, 4'hF, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 32'h1238, 0, 0, 4'hF, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 32'h1238, 0, 0, 4'hF, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 32'h1238, 0, 0, 4'hF, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, WC, 0, 2));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 32'h123C, 0, 0, 4'hF, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, WD, 0, 3));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        // Unaligned write 0x102: rows 23..25 are cycles 1..3.
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 32'h0100, 32'hDEADBEEF, 0, 4'b0011, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));

        bus.req_valid = 0;
        bus.req_write = 0;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        bus.req_byteenable = '0;
        bus.waitrequest = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset req_ready", bus.req_ready, 1);
        chk("reset busy", bus.busy, 0);
        chk("reset read", bus.read, 0);
        chk("reset write", bus.write, 0);
        chk("reset fill_valid", bus.fill_valid, 0);
        chk("reset resp_valid", bus.resp_valid, 0);
        chk("reset address", bus.address, 0);
        chk("reset byteenable", bus.byteenable, 0);
        chk("reset writedata", bus.writedata, 0);
        reset = 0;
        @(negedge clk);

        start_req(0, 32'h1234, 0, 0);
        run_rows(0, 9);
        start_req(0, 32'h1234, 0, 0);
        run_rows(10, 22);
        start_req(1, 32'h0102, 32'hDEADBEEF, 4'b0011);
        run_rows(23, 25);

        // Reset in cycle 5 of a refill, while word 2 is being requested.
        start_req(0, 32'h1234, 0, 0);
        run_rows(0, 3);
        reset = 1;
        #1;
        chk("midreset read before edge", bus.read, 1);
        @(negedge clk);
        #1;
        chk("midreset read", bus.read, 0);
        chk("midreset busy", bus.busy, 0);
        chk("midreset req_ready", bus.req_ready, 1);
        chk("midreset resp_valid", bus.resp_valid, 0);
        reset = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("postreset c%0d resp_valid", c), bus.resp_valid, 0);
            chk($sformatf("postreset c%0d busy", c), bus.busy, 0);
        end

        // Second request held pending through a refill.
        @(negedge clk);
        bus.req_valid = 1;
        bus.req_write = 0;
        bus.req_addr = 32'h1234;
        #1;
        chk("pend first accept", bus.req_ready, 1);
        @(negedge clk);
        bus.req_write = 1;
        bus.req_addr = 32'h2000;
        bus.req_wdata = 32'h1234_5678;
        bus.req_byteenable = 4'hF;
        for (int c = 1; c <= 9; c++) begin
            #1;
            chk($sformatf("pend c%0d req_ready", c), bus.req_ready, 0);
            chk($sformatf("pend c%0d write", c), bus.write, 0);
            chk($sformatf("pend c%0d resp_valid", c), bus.resp_valid, c == 9);
            @(negedge clk);
        end
        #1;
        chk("pend c10 req_ready", bus.req_ready, 1);
        chk("pend c10 read", bus.read, 0);
        chk("pend c10 write", bus.write, 0);
        @(negedge clk);
        bus.req_valid = 0;
        #1;
        chk("pend c11 write", bus.write, 1);
        chk("pend c11 read", bus.read, 0);
        chk("pend c11 address", bus.address, 32'h2000);
        chk("pend c11 writedata", bus.writedata, 32'h1234_5678);
        @(negedge clk);
        #1;
        chk("pend c12 resp_valid", bus.resp_valid, 1);
        @(negedge clk);
        #1;
        chk("pend c13 req_ready", bus.req_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
